// File: rtl/huffman_pkg.sv
`default_nettype none
// ==== huffman_pkg : sizes, FSM states and table entry type for the Huffman stream decoder (rev 1.0) ====
package huffman_pkg;

  localparam int NUM_CODES   = 10;
  localparam int MAX_LEN     = 9;
  localparam int NUM_SYMBOLS = 256;
  localparam int SYM_W       = 4;
  localparam int LEN_W       = 4;
  localparam int IDX_W       = 9;

  typedef enum logic [2:0] {
    IDLE,
    TABLE,
    DATA,
    DONE,
    ERROR
  } dec_state_t;

  // Codes are right-aligned: the first received bit sits at position len-1.
  typedef struct packed {
    logic [MAX_LEN-1:0] code;
    logic [LEN_W-1:0]   len;
  } code_entry_t;

endpackage
`default_nettype wire

// File: rtl/huffman_code_matcher.sv
`default_nettype none
// ==== huffman_code_matcher : combinational table lookup, lowest matching symbol wins (rev 1.0) ====
module huffman_code_matcher
  import huffman_pkg::*;
(
  input  code_entry_t [NUM_CODES-1:0] entries,
  input  logic [MAX_LEN-1:0]          cand,
  input  logic [LEN_W-1:0]            clen,
  output logic                        hit,
  output logic [SYM_W-1:0]            sym
);

  logic [MAX_LEN-1:0] mask;

  always_comb begin
    mask = '0;
    for (int b = 0; b < MAX_LEN; b++) begin
      mask[b] = (LEN_W'(b) < clen);
    end
  end

  // Scan from the top so the lowest index overwrites any higher duplicate.
  always_comb begin
    hit = 1'b0;
    sym = '0;
    for (int i = NUM_CODES - 1; i >= 0; i--) begin
      if ((entries[i].len == clen) && ((entries[i].code & mask) == (cand & mask))) begin
        hit = 1'b1;
        sym = SYM_W'(i);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/huffman_stream_decoder.sv
`default_nettype none
// ==== huffman_stream_decoder : learns a 10-entry code table, then prefix-decodes a symbol frame (rev 1.0) ====
module huffman_stream_decoder
  import huffman_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             bit_valid,
  input  logic             bit_data,
  input  logic             sym_end,
  output logic             sym_valid,
  output logic [SYM_W-1:0] sym_out,
  output logic [IDX_W-1:0] sym_index,
  output logic             table_ready,
  output logic             done,
  output logic             err
);

  localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_LEN);
  localparam logic [3:0]       LAST_TBL = 4'(NUM_CODES - 1);
  localparam logic [IDX_W-1:0] LAST_SYM = IDX_W'(NUM_SYMBOLS - 1);
  localparam logic [IDX_W-1:0] CNT_SAT  = IDX_W'(NUM_SYMBOLS);

  dec_state_t                  state, state_next;
  code_entry_t [NUM_CODES-1:0] tbl;
  logic [MAX_LEN-1:0]          acc;
  logic [LEN_W-1:0]            acc_len;
  logic [3:0]                  tbl_idx;
  logic [IDX_W-1:0]            data_cnt;

  logic [MAX_LEN-1:0] cand;
  logic [LEN_W-1:0]   clen;
  logic               hit;
  logic [SYM_W-1:0]   hit_sym;
  logic               acc_keep, tbl_store, data_hit, go_err;

  assign cand = {acc[MAX_LEN-2:0], bit_data};
  assign clen = acc_len + 1'b1;

  huffman_code_matcher u_matcher (
    .entries (tbl),
    .cand    (cand),
    .clen    (clen),
    .hit     (hit),
    .sym     (hit_sym)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    acc_keep   = 1'b0;
    tbl_store  = 1'b0;
    data_hit   = 1'b0;
    go_err     = 1'b0;
    if (start) begin
      state_next = TABLE;
    end else if (bit_valid) begin
      case (state)
        TABLE: begin
          // A 10th bit cannot fit in the accumulator, with or without sym_end.
          if (acc_len == LEN_MAX) begin
            go_err     = 1'b1;
            state_next = ERROR;
          end else if (sym_end) begin
            tbl_store = 1'b1;
            if (tbl_idx == LAST_TBL) state_next = DATA;
          end else begin
            acc_keep = 1'b1;
          end
        end
        DATA: begin
          if (hit) begin
            data_hit = 1'b1;
            if (data_cnt == LAST_SYM) state_next = DONE;
          end else if (clen == LEN_MAX) begin
            go_err     = 1'b1;
            state_next = ERROR;
          end else begin
            acc_keep = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || start) begin
      tbl         <= '0;
      acc         <= '0;
      acc_len     <= '0;
      tbl_idx     <= '0;
      data_cnt    <= '0;
      sym_valid   <= 1'b0;
      sym_out     <= '0;
      sym_index   <= '0;
      table_ready <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      sym_valid <= 1'b0;
      if (acc_keep) begin
        acc     <= cand;
        acc_len <= clen;
      end
      if (tbl_store) begin
        tbl[tbl_idx] <= '{code: cand, len: clen};
        acc          <= '0;
        acc_len      <= '0;
        tbl_idx      <= tbl_idx + 1'b1;
        if (tbl_idx == LAST_TBL) table_ready <= 1'b1;
      end
      if (data_hit) begin
        sym_valid <= 1'b1;
        sym_out   <= hit_sym;
        sym_index <= data_cnt;
        acc       <= '0;
        acc_len   <= '0;
        if (data_cnt != CNT_SAT)  data_cnt <= data_cnt + 1'b1;
        if (data_cnt == LAST_SYM) done     <= 1'b1;
      end
      if (go_err) err <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_huffman_stream_decoder.sv
`default_nettype none
// ==== tb_huffman_stream_decoder : random and directed frames checked against a string-based decode model (rev 1.0) ====
module tb_huffman_stream_decoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       bit_valid = 1'b0;
  logic       bit_data = 1'b0;
  logic       sym_end = 1'b0;
  logic       sym_valid;
  logic [3:0] sym_out;
  logic [8:0] sym_index;
  logic       table_ready;
  logic       done;
  logic       err;

  huffman_stream_decoder dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .bit_valid   (bit_valid),
    .bit_data    (bit_data),
    .sym_end     (sym_end),
    .sym_valid   (sym_valid),
    .sym_out     (sym_out),
    .sym_index   (sym_index),
    .table_ready (table_ready),
    .done        (done),
    .err         (err)
  );

  always #5 clk = ~clk;

  localparam int M_IDLE = 0, M_TABLE = 1, M_DATA = 2, M_DONE = 3, M_ERR = 4;

  int    checks = 0;
  int    errors = 0;

  // Reference model: the table is a list of bit strings, decoding is string equality.
  int    m_mode = M_IDLE;
  string m_tbl[10];
  string m_acc = "";
  int    m_tidx = 0;
  int    m_cnt = 0;
  bit    m_ready = 0, m_done = 0, m_err = 0;
  bit    exp_v;
  int    exp_sym, exp_idx;
  string load_codes[10];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 10; i++) m_tbl[i] = "";
    m_acc = ""; m_tidx = 0; m_cnt = 0;
    m_ready = 0; m_done = 0; m_err = 0;
  endtask

  task automatic model_table_bit(input bit b, input bit e);
    if (m_acc.len() == 9) begin
      m_err = 1; m_mode = M_ERR;
      return;
    end
    m_acc = {m_acc, (b ? "1" : "0")};
    if (e) begin
      m_tbl[m_tidx] = m_acc;
      m_acc = "";
      m_tidx++;
      if (m_tidx == 10) begin m_ready = 1; m_mode = M_DATA; end
    end
  endtask

  task automatic model_data_bit(input bit b);
    m_acc = {m_acc, (b ? "1" : "0")};
    for (int i = 0; i < 10; i++) begin
      if (m_tbl[i] == m_acc) begin
        exp_v = 1; exp_sym = i;
        break;
      end
    end
    if (exp_v) begin
      exp_idx = m_cnt; m_cnt++; m_acc = "";
      if (m_cnt == 256) begin m_done = 1; m_mode = M_DONE; end
    end else if (m_acc.len() == 9) begin
      m_err = 1; m_mode = M_ERR;
    end
  endtask

  // One clock: drive at negedge, sample 1 ns after the rising edge, compare with the model.
  task automatic step(input bit bv, input bit bd, input bit se, input bit st);
    @(negedge clk);
    bit_valid = bv; bit_data = bd; sym_end = se; start = st;
    @(posedge clk);
    #1;
    exp_v = 0;
    if (!rst_n) begin
      model_clear(); m_mode = M_IDLE;
    end else if (st) begin
      model_clear(); m_mode = M_TABLE;
    end else if (bv && m_mode == M_TABLE) begin
      model_table_bit(bd, se);
    end else if (bv && m_mode == M_DATA) begin
      model_data_bit(bd);
    end
    check("sym_valid", 32'(sym_valid), 32'(exp_v));
    if (exp_v) begin
      check("sym_out", 32'(sym_out), 32'(exp_sym));
      check("sym_index", 32'(sym_index), 32'(exp_idx));
    end
    check("err", 32'(err), 32'(m_err));
    check("done", 32'(done), 32'(m_done));
    check("table_ready", 32'(table_ready), 32'(m_ready));
  endtask

  task automatic send_bits(input string c, input bit tbl_end);
    for (int i = 0; i < c.len(); i++)
      step(1'b1, c.getc(i) == "1", tbl_end && (i == c.len() - 1), 1'b0);
  endtask

  task automatic load_table();
    for (int i = 0; i < 10; i++) send_bits(load_codes[i], 1'b1);
  endtask

  task automatic set_std_codes();
    for (int i = 0; i < 10; i++) begin
      load_codes[i] = "";
      for (int k = 0; k < i; k++) load_codes[i] = {load_codes[i], "1"};
      if (i < 9) load_codes[i] = {load_codes[i], "0"};
    end
  endtask

  task automatic set_rev_codes();
    for (int i = 0; i < 10; i++) begin
      load_codes[i] = "";
      for (int k = 0; k < i; k++) load_codes[i] = {load_codes[i], "0"};
      if (i < 9) load_codes[i] = {load_codes[i], "1"};
    end
  endtask

  task automatic send_random_syms(input int n);
    int s;
    for (int k = 0; k < n; k++) begin
      s = $urandom_range(0, 9);
      send_bits(m_tbl[s], 1'b0);
    end
  endtask

  initial begin
    // Reset state
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check("rst_sym_out", 32'(sym_out), 32'd0);
    check("rst_sym_index", 32'(sym_index), 32'd0);
    rst_n = 1'b1;

    // Bits in IDLE are ignored
    send_bits("0101", 1'b0);

    // Directed table and the three example symbols, then the rest of a full random frame
    set_std_codes();
    step(1'b0, 1'b0, 1'b0, 1'b1);
    load_table();
    send_bits("0", 1'b0);
    send_bits("10", 1'b0);
    send_bits("111111111", 1'b0);
    send_bits("0", 1'b0);
    send_bits("0", 1'b0);
    send_random_syms(251);
    check("frame_done", 32'(done), 32'd1);
    check("frame_count", 32'(m_cnt), 32'd256);
    send_bits("0010", 1'b0);

    // Over-long table entry
    step(1'b0, 1'b0, 1'b0, 1'b1);
    send_bits("1111111111", 1'b0);
    check("overlong_err", 32'(err), 32'd1);
    send_bits("0100", 1'b0);

    // Duplicate codes: lowest index wins, then an undecodable 9-bit word
    set_std_codes();
    load_codes[8] = "111111110";
    load_codes[9] = "111111110";
    step(1'b0, 1'b0, 1'b0, 1'b1);
    load_table();
    send_bits("111111110", 1'b0);
    send_bits("111111111", 1'b0);
    check("nomatch_err", 32'(err), 32'd1);
    send_bits("0", 1'b0);

    // Restart after 100 data symbols with a different table
    set_rev_codes();
    step(1'b0, 1'b0, 1'b0, 1'b1);
    load_table();
    send_random_syms(100);
    send_bits("0", 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    set_std_codes();
    load_table();
    send_random_syms(3);

    // Reset in the middle of a data codeword
    send_bits("11", 1'b0);
    rst_n = 1'b0;
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check("mid_rst_sym_out", 32'(sym_out), 32'd0);
    check("mid_rst_sym_index", 32'(sym_index), 32'd0);
    rst_n = 1'b1;
    send_bits("0100", 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    load_table();
    send_random_syms(20);
    step(1'b0, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
